// File: rtl/fpga_io_pkg.sv
// -----------------------------------------------------------------------------
// fpga_io_pkg
// Shared constants for the FPGA-side GPIO pad controller.
//   - default values for the gpio_pad_ctrl parameters
//   - db_smp_w(): width of a debounce sample counter able to hold 0..samples
//   - DB_SMP_W:   that width for the default DB_SAMPLES
// -----------------------------------------------------------------------------
package fpga_io_pkg;

    localparam int NUM_PINS_DEF    = 32;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CNT_W_DEF    = 16;
    localparam int DB_SAMPLES_DEF  = 4;

    // Counter width needed to count up to 'samples' inclusive.
    function automatic int db_smp_w(input int samples);
        return $clog2(samples + 1);
    endfunction

    localparam int DB_SMP_W = $clog2(DB_SAMPLES_DEF + 1);

endpackage

// File: rtl/gpio_db_ch.sv
// -----------------------------------------------------------------------------
// gpio_db_ch
// One GPIO input channel: synchroniser chain, debounce filter, edge detector
// and sticky interrupt-pending flag.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   pad_i                raw asynchronous pad level
//   db_en_i              debounce enable for this pin
//   tick_i               shared prescaler tick (one cycle wide)
//   irq_rise_en_i        rising-edge interrupt enable
//   irq_fall_en_i        falling-edge interrupt enable
//   irq_clr_i            write-1-to-clear pulse for the pending flag
//   core_i_o             filtered level ("stable"), registered
//   irq_pend_o           sticky pending flag, registered
// -----------------------------------------------------------------------------
module gpio_db_ch
    import fpga_io_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_SAMPLES  = DB_SAMPLES_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic pad_i,
    input  logic db_en_i,
    input  logic tick_i,
    input  logic irq_rise_en_i,
    input  logic irq_fall_en_i,
    input  logic irq_clr_i,
    output logic core_i_o,
    output logic irq_pend_o
);

    localparam int              SMP_W    = db_smp_w(DB_SAMPLES);
    // The accepting tick is the one that would bring the count to DB_SAMPLES.
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(DB_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [SMP_W-1:0]       smp_cnt_r;
    logic                   stable_r;
    logic                   prev_r;
    logic                   pend_r;
    logic                   rise_s;
    logic                   fall_s;
    logic                   set_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain bringing the asynchronous pad level into clk_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Debounce: accept a new level only after DB_SAMPLES consecutive differing ticks.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stable_r  <= 1'b0;
            smp_cnt_r <= '0;
        end else if (!db_en_i) begin
            // Filter bypassed: follow the synchroniser and drop any partial count.
            stable_r  <= sync_s;
            smp_cnt_r <= '0;
        end else if (tick_i) begin
            if (sync_s != stable_r) begin
                if (smp_cnt_r == SMP_LAST) begin
                    stable_r  <= sync_s;
                    smp_cnt_r <= '0;
                end else begin
                    stable_r  <= stable_r;
                    smp_cnt_r <= smp_cnt_r + SMP_W'(1);
                end
            end else begin
                // Level returned to the accepted value: restart the run.
                stable_r  <= stable_r;
                smp_cnt_r <= '0;
            end
        end else begin
            stable_r  <= stable_r;
            smp_cnt_r <= smp_cnt_r;
        end
    end

    // Edge qualification against the per-pin enables.
    always_comb begin
        rise_s = 1'b0;
        fall_s = 1'b0;
        set_s  = 1'b0;
        rise_s = stable_r & ~prev_r;
        fall_s = ~stable_r & prev_r;
        set_s  = (rise_s & irq_rise_en_i) | (fall_s & irq_fall_en_i);
    end

    // Previous filtered level and sticky pending flag (a new edge beats a clear).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev_r <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            prev_r <= stable_r;
            pend_r <= set_s | (pend_r & ~irq_clr_i);
        end
    end

    assign core_i_o   = stable_r;
    assign irq_pend_o = pend_r;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_pad_ctrl
// GPIO pad controller between the SoC GPIO ports and the FPGA pins.
// Output path registers core data/enable toward the pads (per-bit tristate is
// done by the FPGA top). Input path synchronises, optionally debounces and
// edge-detects each pin, raising sticky per-pin interrupt flags.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   core_o_i, core_oe_i  output data / per-bit enable from the core
//   core_i_o             filtered input level to the core
//   pad_i                raw pad level (asynchronous)
//   pad_o, pad_oe        registered pad drive value / per-bit enable
//   db_en_i              per-pin debounce enable
//   db_div_i             debounce prescaler terminal count
//   irq_rise_en_i        rising-edge interrupt enables
//   irq_fall_en_i        falling-edge interrupt enables
//   irq_clr_i            write-1-to-clear pulses
//   irq_pend_o           sticky pending flags
//   irq_o                OR of all pending flags
// -----------------------------------------------------------------------------
module gpio_pad_ctrl
    import fpga_io_pkg::*;
#(
    parameter int NUM_PINS    = NUM_PINS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CNT_W    = DB_CNT_W_DEF,
    parameter int DB_SAMPLES  = DB_SAMPLES_DEF
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [NUM_PINS-1:0] core_o_i,
    input  logic [NUM_PINS-1:0] core_oe_i,
    output logic [NUM_PINS-1:0] core_i_o,
    input  logic [NUM_PINS-1:0] pad_i,
    output logic [NUM_PINS-1:0] pad_o,
    output logic [NUM_PINS-1:0] pad_oe,
    input  logic [NUM_PINS-1:0] db_en_i,
    input  logic [DB_CNT_W-1:0] db_div_i,
    input  logic [NUM_PINS-1:0] irq_rise_en_i,
    input  logic [NUM_PINS-1:0] irq_fall_en_i,
    input  logic [NUM_PINS-1:0] irq_clr_i,
    output logic [NUM_PINS-1:0] irq_pend_o,
    output logic                irq_o
);

    logic [DB_CNT_W-1:0] pre_cnt_r;
    logic                tick_s;
    logic [NUM_PINS-1:0] pad_o_r;
    logic [NUM_PINS-1:0] pad_oe_r;

    // Using >= rather than == makes a lowered terminal count take effect at once.
    assign tick_s = (pre_cnt_r >= db_div_i);

    // Shared debounce prescaler: reload to zero on each tick.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + DB_CNT_W'(1);
        end
    end

    // Output path: one register stage core -> pad, every bit independent.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pad_o_r  <= '0;
            pad_oe_r <= '0;
        end else begin
            pad_o_r  <= core_o_i;
            pad_oe_r <= core_oe_i;
        end
    end

    assign pad_o  = pad_o_r;
    assign pad_oe = pad_oe_r;

    for (genvar k = 0; k < NUM_PINS; k++) begin : g_ch
        gpio_db_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_SAMPLES  (DB_SAMPLES)
        ) u_ch (
            .clk_i         (clk_i),
            .rstn_i        (rstn_i),
            .pad_i         (pad_i[k]),
            .db_en_i       (db_en_i[k]),
            .tick_i        (tick_s),
            .irq_rise_en_i (irq_rise_en_i[k]),
            .irq_fall_en_i (irq_fall_en_i[k]),
            .irq_clr_i     (irq_clr_i[k]),
            .core_i_o      (core_i_o[k]),
            .irq_pend_o    (irq_pend_o[k])
        );
    end

    assign irq_o = |irq_pend_o;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_pad_ctrl
// Self-checking bench for gpio_pad_ctrl (32 pins, 2 sync stages, 4 samples).
// -----------------------------------------------------------------------------
module tb_gpio_pad_ctrl;

    localparam int N  = 32;
    localparam int RN = 200;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic [N-1:0]  core_o_i, core_oe_i, core_i_o, pad_i, pad_o, pad_oe;
    logic [N-1:0]  db_en_i, irq_rise_en_i, irq_fall_en_i, irq_clr_i, irq_pend_o;
    logic [15:0]   db_div_i;
    logic          irq_o;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(
        .NUM_PINS(32), .SYNC_STAGES(2), .DB_CNT_W(16), .DB_SAMPLES(4)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .core_o_i(core_o_i), .core_oe_i(core_oe_i), .core_i_o(core_i_o),
        .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe),
        .db_en_i(db_en_i), .db_div_i(db_div_i),
        .irq_rise_en_i(irq_rise_en_i), .irq_fall_en_i(irq_fall_en_i),
        .irq_clr_i(irq_clr_i), .irq_pend_o(irq_pend_o), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] co;
        logic [31:0] coe;
        logic [31:0] epo;
        logic [31:0] epoe;
    } out_vec_t;

    out_vec_t tbl[5];

    // reference histories for the random phase (index = cycle driven)
    logic [31:0] pad_h [RN];
    logic [31:0] ren_h [RN];
    logic [31:0] fen_h [RN];
    logic [31:0] clr_h [RN];
    logic [31:0] co_h  [RN];
    logic [31:0] coe_h [RN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_o_i = '0; core_oe_i = '0; pad_i = '0; db_en_i = '0;
        db_div_i = 16'd0; irq_rise_en_i = '0; irq_fall_en_i = '0; irq_clr_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn_i = 1'b0;
        step();
        step();
        rstn_i = 1'b1;
    endtask

    // Filtered level after edge n with debounce off: the pad value three edges back.
    function automatic logic [31:0] stable_at(input int n);
        if (n >= 3) return pad_h[n-3];
        else        return 32'd0;
    endfunction

    initial begin
        logic [31:0] pend_m, set_m, padv, s_now, s_prev;
        logic [31:0] prev_po, prev_poe;
        logic        seen, last_ci, got;
        int          rises, first_lat;

        tbl[0] = '{32'hA5A5_A5A5, 32'h0000_00F0, 32'hA5A5_A5A5, 32'h0000_00F0};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[2] = '{32'h0000_0000, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_FFFF};
        tbl[3] = '{32'h1234_5678, 32'h8000_0001, 32'h1234_5678, 32'h8000_0001};
        tbl[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};

        // ---- reset state ----
        do_reset();
        check("rst_pad_o", pad_o, 32'd0);
        check("rst_pad_oe", pad_oe, 32'd0);
        check("rst_core_i", core_i_o, 32'd0);
        check("rst_pend", irq_pend_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);

        // ---- output path table: unchanged before the edge, new value after ----
        prev_po = 32'd0; prev_poe = 32'd0;
        for (int i = 0; i < 5; i++) begin
            core_o_i  = tbl[i].co;
            core_oe_i = tbl[i].coe;
            #1;
            check("out_hold_o", pad_o, prev_po);
            check("out_hold_oe", pad_oe, prev_poe);
            step();
            check("out_pad_o", pad_o, tbl[i].epo);
            check("out_pad_oe", pad_oe, tbl[i].epoe);
            prev_po = tbl[i].epo; prev_poe = tbl[i].epoe;
        end

        // ---- debounce off, pin 3 rise ----
        do_reset();
        irq_rise_en_i[3] = 1'b1;
        pad_i[3] = 1'b1;
        step(); step();
        check("p3_core_2cyc", {31'd0, core_i_o[3]}, 32'd0);
        step();
        check("p3_core_3cyc", {31'd0, core_i_o[3]}, 32'd1);
        check("p3_pend_3cyc", {31'd0, irq_pend_o[3]}, 32'd0);
        step();
        check("p3_pend_4cyc", {31'd0, irq_pend_o[3]}, 32'd1);
        check("p3_irq_4cyc", {31'd0, irq_o}, 32'd1);

        // ---- interrupt modes on pin 5 ----
        do_reset();
        irq_rise_en_i[5] = 1'b1; irq_fall_en_i[5] = 1'b1;
        pad_i[5] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("p5_rise_pend", {31'd0, irq_pend_o[5]}, 32'd1);
        irq_clr_i[5] = 1'b1; step(); irq_clr_i[5] = 1'b0;
        check("p5_clr", {31'd0, irq_pend_o[5]}, 32'd0);
        pad_i[5] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("p5_fall_pre", {31'd0, irq_pend_o[5]}, 32'd0);
        irq_clr_i[5] = 1'b1; step(); irq_clr_i[5] = 1'b0;
        check("p5_set_wins", {31'd0, irq_pend_o[5]}, 32'd1);
        irq_clr_i[5] = 1'b1; step(); irq_clr_i[5] = 1'b0;
        check("p5_lone_clr", {31'd0, irq_pend_o[5]}, 32'd0);
        pad_i[5] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("p5_rise2", {31'd0, irq_pend_o[5]}, 32'd1);

        // ---- prescaler: lower terminal count mid-period ----
        do_reset();
        db_div_i = 16'd9;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (dut.tick_s) got = 1'b1;
            else step();
        end
        check("pre_tick_seen", {31'd0, got}, 32'd1);
        step();                                  // count reloads to 0
        for (int i = 0; i < 7; i++) step();      // count now 7
        check("pre_no_tick_at7", {31'd0, dut.tick_s}, 32'd0);
        db_div_i = 16'd2;
        #1;
        check("pre_tick_lowered", {31'd0, dut.tick_s}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("pre_period3", {31'd0, dut.tick_s}, (i % 3 == 2) ? 32'd1 : 32'd0);
        end

        // ---- debounce on, pin 0, db_div=9 ----
        do_reset();
        db_div_i = 16'd9; db_en_i[0] = 1'b1; irq_rise_en_i[0] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        seen = 1'b0;
        for (int i = 0; i < 75; i++) begin
            pad_i[0] = (i < 15);
            step();
            if (core_i_o[0] || irq_pend_o[0]) seen = 1'b1;
        end
        check("db_glitch_blocked", {31'd0, seen}, 32'd0);
        rises = 0; first_lat = 0; last_ci = core_i_o[0];
        for (int i = 0; i < 120; i++) begin
            pad_i[0] = (i < 60);
            step();
            if (core_i_o[0] && !last_ci) begin
                rises++;
                if (rises == 1) first_lat = i + 1;
            end
            last_ci = core_i_o[0];
        end
        check("db_one_rise", rises, 32'd1);
        check("db_latency_ok", {31'd0, (first_lat >= 1 && first_lat <= 43)}, 32'd1);
        check("db_pend", {31'd0, irq_pend_o[0]}, 32'd1);
        check("db_fell_back", {31'd0, core_i_o[0]}, 32'd0);

        // ---- randomized, debounce off, against a delay-line model ----
        do_reset();
        pend_m = 32'd0;
        padv   = 32'd0;
        for (int k = 0; k < RN; k++) begin
            padv     = padv ^ ($urandom() & $urandom());
            pad_h[k] = padv;
            ren_h[k] = $urandom();
            fen_h[k] = $urandom();
            clr_h[k] = $urandom() & $urandom() & $urandom();
            co_h[k]  = $urandom();
            coe_h[k] = $urandom();
            pad_i = pad_h[k]; irq_rise_en_i = ren_h[k]; irq_fall_en_i = fen_h[k];
            irq_clr_i = clr_h[k]; core_o_i = co_h[k]; core_oe_i = coe_h[k];
            s_now  = stable_at(k);
            s_prev = stable_at(k - 1);
            set_m  = (s_now & ~s_prev & ren_h[k]) | (~s_now & s_prev & fen_h[k]);
            pend_m = set_m | (pend_m & ~clr_h[k]);
            step();
            check("rnd_core_i", core_i_o, stable_at(k + 1));
            check("rnd_pend", irq_pend_o, pend_m);
            check("rnd_irq", {31'd0, irq_o}, {31'd0, |pend_m});
            check("rnd_pad_o", pad_o, co_h[k]);
            check("rnd_pad_oe", pad_oe, coe_h[k]);
        end

        // ---- asynchronous reset mid-traffic ----
        irq_clr_i = '0;
        core_oe_i = 32'hFFFF_FFFF;
        core_o_i  = 32'h5A5A_F00F;
        step(); step();
        check("arst_pre_oe", pad_oe, 32'hFFFF_FFFF);
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_pad_oe", pad_oe, 32'd0);
        check("arst_pad_o", pad_o, 32'd0);
        check("arst_core_i", core_i_o, 32'd0);
        check("arst_pend", irq_pend_o, 32'd0);
        check("arst_irq", {31'd0, irq_o}, 32'd0);
        step();
        rstn_i = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Parametrised GPIO pad controller between `soc_top` GPIO ports and FPGA pins. Registers per-bit output/enable toward the pads (per-bit tristate at the top level, no vector-wide enable), synchronises and optionally debounces pad inputs, and raises per-pin edge interrupts. Instantiated once in the FPGA top, in the `clk_i` domain.

## Interface
Parameters:
- `NUM_PINS`, 32, number of GPIO pins
- `SYNC_STAGES`, 2, input synchroniser depth (legal ≥ 2)
- `DB_CNT_W`, 16, debounce prescaler width
- `DB_SAMPLES`, 4, consecutive differing ticks required to accept a new level (legal ≥ 1)

Ports:
- `clk_i` in 1, system clock; the single clock of the block
- `rstn_i` in 1, reset, asynchronous, active-low
- `core_o_i` in NUM_PINS, output data from the core
- `core_oe_i` in NUM_PINS, per-bit output enable from the core
- `core_i_o` out NUM_PINS, filtered input level to the core
- `pad_i` in NUM_PINS, raw pad level (asynchronous)
- `pad_o` out NUM_PINS, registered pad drive value
- `pad_oe` out NUM_PINS, registered per-bit pad enable
- `db_en_i` in NUM_PINS, per-pin debounce enable
- `db_div_i` in DB_CNT_W, prescaler terminal count
- `irq_rise_en_i` in NUM_PINS, rising-edge interrupt enable
- `irq_fall_en_i` in NUM_PINS, falling-edge interrupt enable
- `irq_clr_i` in NUM_PINS, one-cycle write-1-to-clear pulse
- `irq_pend_o` out NUM_PINS, sticky pending flags
- `irq_o` out 1, OR of `irq_pend_o`

## Operation
- Reset (async): every register cleared; `pad_o`=0, `pad_oe`=0 (all pins high-Z), `core_i_o`=0, `irq_pend_o`=0, `irq_o`=0, prescaler and sample counters 0.
- Output path: `pad_o`/`pad_oe` are `core_o_i`/`core_oe_i` delayed one register stage, bit-independent.
- Input path: `pad_i` → SYNC_STAGES flops (reset 0) → `sync`.
- Prescaler (shared): counts up each cycle; when count ≥ `db_div_i`, asserts `tick` for one cycle and reloads 0. `db_div_i`=0 → tick every cycle. Lowering `db_div_i` below the current count → tick next cycle, then normal.
- Per-pin debounce, `db_en_i`=1: register `stable`; on `tick`, if `sync`≠`stable`, increment sample counter, and when it reaches DB_SAMPLES set `stable`=`sync`, counter→0; if `sync`=`stable` on a tick, counter→0. No tick → hold.
- `db_en_i`=0: counter forced 0, `stable` loads `sync` every cycle. Deasserting mid-count discards the count.
- `core_i_o` = `stable`.
- Edge detect: `prev` = `stable` delayed one cycle; rise = `stable & ~prev`, fall = `~stable & prev`.
- Pending: set by (rise & `irq_rise_en_i`) | (fall & `irq_fall_en_i`); cleared by `irq_clr_i`; set and clear same cycle → set wins. Both enables → either edge sets.
- `irq_o` combinational OR of pending register.

## Timing
- Output latency: 1 cycle core → pad.
- Input latency, debounce off: pad change visible on `core_i_o` after SYNC_STAGES+1 rising edges; pending set one cycle later (SYNC_STAGES+2); `irq_o` same cycle as pending.
- Debounce on: new level accepted on the DB_SAMPLES-th consecutive tick observing the difference, plus one cycle; worst case ≈ SYNC_STAGES+1+DB_SAMPLES·(`db_div_i`+1) cycles.
- Glitch shorter than one tick period with debounce on: never reaches `core_i_o`, no interrupt.
- `irq_clr_i` takes effect next cycle.

## Structure
- Package `fpga_io_pkg`: default parameter constants, `DB_SMP_W` = $clog2(DB_SAMPLES+1) counter width.
- Sub-module `gpio_db_ch`: one pin's sync chain, debounce counter, `stable`, `prev`, pending flag; generate loop of NUM_PINS. Prescaler and output registers in `gpio_pad_ctrl`.
- FPGA top performs per-bit tristate: `gpio[k] = pad_oe[k] ? pad_o[k] : 1'bz`.

## Test plan
- Reset: assert `rstn_i`=0 mid-traffic with `core_oe_i`=all-ones → all outputs 0 asynchronously, `pad_oe`=0 before next edge.
- Output: `core_oe_i`=0x0000_00F0, `core_o_i`=0xA5A5_A5A5 → one cycle later `pad_oe`=0x0000_00F0, `pad_o`=0xA5A5_A5A5.
- Debounce off: pin 3 rises, rise enable on → `core_i_o[3]`=1 after 3 cycles, `irq_pend_o[3]`=1 and `irq_o`=1 after 4 (SYNC_STAGES=2).
- Debounce on, `db_div_i`=9, DB_SAMPLES=4: 15-cycle pulse on pin 0 → no change; 60-cycle pulse → `core_i_o[0]` rises once, ≤ 43 cycles after edge.
- Interrupt modes: pin 5 both enables, toggle 1→0→1 → pending set each edge; `irq_clr_i[5]` coincident with new edge → pending stays 1; lone clear → 0 next cycle.
- Prescaler: count at 7, `db_div_i` lowered 9→2 → tick next cycle, then every 3 cycles.
